// File: rtl/cpu_memory.sv
// rtl/cpu_memory.sv - Rv32H memory-access stage: load/store over a word bus, republish to writeback
module cpu_memory (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [7:0]  i_tag,
  input  logic [4:0]  i_inst_rd,
  input  logic [31:0] i_rd,
  input  logic [31:0] i_pc_next,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_mem_width,
  input  logic        i_mem_signed,
  input  logic [31:0] i_rs2,
  output logic        o_busy,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wmask,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic        o_misaligned,
  output logic [7:0]  o_tag,
  output logic [4:0]  o_inst_rd,
  output logic [31:0] o_rd,
  output logic [31:0] o_pc_next
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]  state;
  logic [7:0]  lat_tag;
  logic [4:0]  lat_inst_rd;
  logic [31:0] lat_pc_next;
  logic [31:0] lat_addr;
  logic [2:0]  lat_width;
  logic        lat_signed;

  logic        new_inst;
  logic        mem_op;
  logic        misaligned;
  logic [31:0] store_wdata;
  logic [3:0]  store_wmask;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign new_inst = (i_tag != o_tag);
  assign mem_op   = i_mem_read | i_mem_write;

  always_comb begin
    misaligned  = 1'b0;
    store_wdata = i_rs2;
    store_wmask = 4'b1111;
    case (i_mem_width)
      3'd1: begin
        store_wdata = {4{i_rs2[7:0]}};
        store_wmask = 4'b0001 << i_rd[1:0];
      end
      3'd2: begin
        misaligned  = i_rd[0];
        store_wdata = {2{i_rs2[15:0]}};
        store_wmask = i_rd[1] ? 4'b1100 : 4'b0011;
      end
      default: misaligned = (i_rd[1:0] != 2'b00);
    endcase
  end

  // Lane selection uses the latched address so it is stable across wait states.
  always_comb begin
    load_byte = i_bus_rdata[8*lat_addr[1:0] +: 8];
    load_half = i_bus_rdata[16*lat_addr[1] +: 16];
    case (lat_width)
      3'd1:    load_data = {{24{lat_signed & load_byte[7]}}, load_byte};
      3'd2:    load_data = {{16{lat_signed & load_half[15]}}, load_half};
      default: load_data = i_bus_rdata;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      o_tag         <= 8'd0;
      o_inst_rd     <= 5'd0;
      o_rd          <= 32'd0;
      o_pc_next     <= 32'd0;
      o_busy        <= 1'b0;
      o_bus_request <= 1'b0;
      o_bus_rw      <= 1'b0;
      o_bus_address <= 32'd0;
      o_bus_wdata   <= 32'd0;
      o_bus_wmask   <= 4'd0;
      o_misaligned  <= 1'b0;
      lat_tag       <= 8'd0;
      lat_inst_rd   <= 5'd0;
      lat_pc_next   <= 32'd0;
      lat_addr      <= 32'd0;
      lat_width     <= 3'd0;
      lat_signed    <= 1'b0;
    end else begin
      o_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (new_inst) begin
            if (mem_op && !misaligned) begin
              lat_tag       <= i_tag;
              lat_inst_rd   <= i_inst_rd;
              lat_pc_next   <= i_pc_next;
              lat_addr      <= i_rd;
              lat_width     <= i_mem_width;
              lat_signed    <= i_mem_signed;
              o_bus_request <= 1'b1;
              o_busy        <= 1'b1;
              o_bus_rw      <= i_mem_write;
              o_bus_address <= {i_rd[31:2], 2'b00};
              o_bus_wdata   <= store_wdata;
              o_bus_wmask   <= i_mem_write ? store_wmask : 4'b0000;
              state         <= ACCESS;
            end else begin
              o_tag        <= i_tag;
              o_inst_rd    <= i_inst_rd;
              o_rd         <= i_rd;
              o_pc_next    <= i_pc_next;
              o_misaligned <= mem_op;
            end
          end
        end
        default: begin
          // All published fields move together so writeback never sees a stale o_rd.
          if (i_bus_ready) begin
            o_bus_request <= 1'b0;
            o_busy        <= 1'b0;
            o_tag         <= lat_tag;
            o_inst_rd     <= lat_inst_rd;
            o_pc_next     <= lat_pc_next;
            o_rd          <= o_bus_rw ? lat_addr : load_data;
            state         <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
